// File: rtl/softmax_pkg.sv
// -----------------------------------------------------------------------------
// softmax_pkg
// Shared definitions for the softmax normaliser slice.
//   state_e      : normaliser FSM states
//   *_FRAC       : fractional bit counts of the fixed-point formats in use
//                  (exponent Q4.12, sum Q6.26, reciprocal Q16.16, output Q1.15)
//   PROD_SHIFT   : right shift that takes a Q4.12 x Q16.16 product to Q1.15
//   SAT_THRESH   : sums at or below this raw value give a reciprocal that does
//                  not fit in Q16.16, so the reciprocal saturates
// -----------------------------------------------------------------------------
package softmax_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SUM = 2'd1,
        ST_DIV      = 2'd2,
        ST_SCALE    = 2'd3
    } state_e;

    localparam int unsigned IN_FRAC    = 12;
    localparam int unsigned SUM_FRAC   = 26;
    localparam int unsigned RECIP_FRAC = 16;
    localparam int unsigned OUT_FRAC   = 15;

    // Q(.12) * Q(.16) = Q(.28); keeping 15 fraction bits drops 13.
    localparam int unsigned PROD_SHIFT = IN_FRAC + RECIP_FRAC - OUT_FRAC;

    // Dividend is 2^(SUM_FRAC+RECIP_FRAC) = 2^42. With a 32-bit quotient the
    // quotient overflows exactly when sum <= 2^10.
    localparam int unsigned SAT_EXP    = 10;
    localparam int unsigned SAT_THRESH = 1 << SAT_EXP;

endpackage

// File: rtl/recip_divider.sv
// -----------------------------------------------------------------------------
// recip_divider
// Fixed-latency restoring divider producing recip = floor(2^42 / sum) as an
// unsigned Q16.16 value, one quotient bit per clock, exactly RECIP_W clocks.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : load i_sum and begin a division (ignored result of any
//                    division in flight is discarded)
//   i_sum          : Q6.26 unsigned divisor
//   o_done         : high during the final iteration cycle; o_recip / o_sat
//                    are updated at the end of that cycle
//   o_recip        : Q16.16 reciprocal, all ones when saturated
//   o_sat          : reciprocal saturated; cleared on i_start
// -----------------------------------------------------------------------------
module recip_divider
    import softmax_pkg::*;
#(
    parameter int unsigned SUM_W   = 32,
    parameter int unsigned RECIP_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [SUM_W-1:0]   i_sum,
    output logic               o_done,
    output logic [RECIP_W-1:0] o_recip,
    output logic               o_sat
);

    localparam int unsigned CNT_W = $clog2(RECIP_W + 1);

    logic               busy_q,  busy_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [SUM_W-1:0]   div_q,   div_d;
    logic [SUM_W-1:0]   rem_q,   rem_d;
    logic [RECIP_W-2:0] quot_q,  quot_d;
    logic [RECIP_W-1:0] recip_q, recip_d;
    logic               sat_q,   sat_d;

    logic [SUM_W:0]     trial;
    logic [SUM_W:0]     diff;
    logic               ge;
    logic [RECIP_W-1:0] quot_next;

    always_comb begin
        // Remainder stays below the divisor, so the shifted trial fits in
        // SUM_W+1 bits and the sign of the difference is the compare result.
        trial     = {rem_q, 1'b0};
        diff      = trial - {1'b0, div_q};
        ge        = ~diff[SUM_W];
        quot_next = {quot_q, ge};

        o_done  = busy_q && (cnt_q == CNT_W'(1));

        busy_d  = busy_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        recip_d = recip_q;
        sat_d   = sat_q;

        if (i_start) begin
            busy_d = 1'b1;
            cnt_d  = CNT_W'(RECIP_W);
            div_d  = i_sum;
            // Upper part of the 2^42 dividend; the remaining 32 bits are zero
            // and shift in one per iteration.
            rem_d  = SUM_W'(SAT_THRESH);
            quot_d = '0;
            sat_d  = 1'b0;
        end else if (busy_q) begin
            rem_d  = ge ? diff[SUM_W-1:0] : trial[SUM_W-1:0];
            quot_d = quot_next[RECIP_W-2:0];
            cnt_d  = cnt_q - 1'b1;
            if (o_done) begin
                busy_d  = 1'b0;
                sat_d   = (div_q <= SUM_W'(SAT_THRESH));
                recip_d = sat_d ? '1 : quot_next;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            recip_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            recip_q <= recip_d;
            sat_q   <= sat_d;
        end
    end

    assign o_recip = recip_q;
    assign o_sat   = sat_q;

endmodule

// File: rtl/softmax_normalizer.sv
// -----------------------------------------------------------------------------
// softmax_normalizer
// Captures an N-element Q4.12 exponent vector (negatives clamped to 0) and its
// Q6.26 sum, computes a Q16.16 reciprocal of the sum, then streams the N
// normalised Q1.15 probabilities over a valid/ready handshake.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | ready for a vector; vector (+ optional sum) capture
//   WAIT_SUM  | vector held, waiting for the sum
//   DIV       | reciprocal divider running (RECIP_W cycles)
//   SCALE     | streaming x[i]*recip, one element per accepted beat
//
// Ports:
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_vec_valid / o_vec_ready : vector capture, o_vec_ready only in IDLE
//   i_data                    : N x Q4.12 elements, element i at [i*W +: W]
//   i_sum_valid / i_sum       : Q6.26 sum of the vector
//   o_valid / i_ready         : output handshake for o_prob / o_idx / o_last
//   o_prob                    : Q1.15 probability, saturated to all ones
//   o_idx, o_last             : element index, last element flag
//   o_busy                    : not IDLE
//   o_recip_sat               : reciprocal saturated for the current vector
// -----------------------------------------------------------------------------
module softmax_normalizer
    import softmax_pkg::*;
#(
    parameter int unsigned N             = 32,
    parameter int unsigned IN_BIT_WIDTH  = 16,
    parameter int unsigned SUM_BIT_WIDTH = 32,
    parameter int unsigned RECIP_W       = 32,
    parameter int unsigned OUT_BIT_WIDTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_vec_valid,
    output logic                        o_vec_ready,
    input  logic [IN_BIT_WIDTH*N-1:0]   i_data,
    input  logic                        i_sum_valid,
    input  logic [SUM_BIT_WIDTH-1:0]    i_sum,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [OUT_BIT_WIDTH-1:0]    o_prob,
    output logic [$clog2(N)-1:0]        o_idx,
    output logic                        o_last,
    output logic                        o_busy,
    output logic                        o_recip_sat
);

    localparam int unsigned IDX_W  = $clog2(N);
    // Clamped elements are non-negative, so the sign bit is not stored.
    localparam int unsigned XW     = IN_BIT_WIDTH - 1;
    localparam int unsigned PROD_W = XW + RECIP_W;

    state_e                   state_q, state_d;
    logic [XW-1:0]            x_q [N];
    logic [XW-1:0]            x_d [N];
    logic                     valid_q, valid_d;
    logic                     last_q,  last_d;
    logic [OUT_BIT_WIDTH-1:0] prob_q,  prob_d;
    logic [IDX_W-1:0]         idx_q,   idx_d;

    logic                     div_start;
    logic                     div_done;
    logic [RECIP_W-1:0]       recip;
    logic                     recip_sat;

    logic [IDX_W-1:0]         nidx;
    logic [PROD_W-1:0]        prod;
    logic [PROD_W-1:0]        prod_sh;
    logic [OUT_BIT_WIDTH-1:0] prob_n;

    recip_divider #(
        .SUM_W   (SUM_BIT_WIDTH),
        .RECIP_W (RECIP_W)
    ) u_recip_divider (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (div_start),
        .i_sum   (i_sum),
        .o_done  (div_done),
        .o_recip (recip),
        .o_sat   (recip_sat)
    );

    always_comb begin
        // Element to load into the output register next: 0 on the first beat
        // of a stream, otherwise the one after the element being shown.
        nidx    = valid_q ? idx_q + 1'b1 : '0;
        prod    = PROD_W'(x_q[nidx]) * PROD_W'(recip);
        prod_sh = prod >> PROD_SHIFT;
        prob_n  = (|prod_sh[PROD_W-1:OUT_BIT_WIDTH]) ? '1 : prod_sh[OUT_BIT_WIDTH-1:0];

        state_d   = state_q;
        x_d       = x_q;
        valid_d   = valid_q;
        last_d    = last_q;
        prob_d    = prob_q;
        idx_d     = idx_q;
        div_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_vec_valid) begin
                    for (int i = 0; i < int'(N); i++) begin
                        x_d[i] = i_data[i*IN_BIT_WIDTH + IN_BIT_WIDTH - 1]
                                 ? '0 : i_data[i*IN_BIT_WIDTH +: XW];
                    end
                    if (i_sum_valid) begin
                        div_start = 1'b1;
                        state_d   = ST_DIV;
                    end else begin
                        state_d   = ST_WAIT_SUM;
                    end
                end
            end
            ST_WAIT_SUM: begin
                if (i_sum_valid) begin
                    div_start = 1'b1;
                    state_d   = ST_DIV;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_SCALE;
                end
            end
            ST_SCALE: begin
                if (valid_q && i_ready && last_q) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    prob_d  = '0;
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else if (!valid_q || i_ready) begin
                    valid_d = 1'b1;
                    prob_d  = prob_n;
                    idx_d   = nidx;
                    last_d  = (nidx == IDX_W'(N - 1));
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < int'(N); i++) begin
                x_q[i] <= '0;
            end
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            prob_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            prob_q  <= prob_d;
            idx_q   <= idx_d;
        end
    end

    assign o_vec_ready = (state_q == ST_IDLE);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_valid     = valid_q;
    assign o_last      = last_q;
    assign o_prob      = prob_q;
    assign o_idx       = idx_q;
    assign o_recip_sat = recip_sat;

endmodule

// File: tb/tb_softmax_normalizer.sv
module tb_softmax_normalizer;

    localparam int N    = 32;
    localparam int INW  = 16;
    localparam int SW   = 32;
    localparam int RW   = 32;
    localparam int OW   = 16;
    localparam int IDXW = 5;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_vec_valid = 1'b0;
    logic              o_vec_ready;
    logic [INW*N-1:0]  i_data = '0;
    logic              i_sum_valid = 1'b0;
    logic [SW-1:0]     i_sum = '0;
    logic              o_valid;
    logic              i_ready = 1'b0;
    logic [OW-1:0]     o_prob;
    logic [IDXW-1:0]   o_idx;
    logic              o_last;
    logic              o_busy;
    logic              o_recip_sat;

    softmax_normalizer #(
        .N             (N),
        .IN_BIT_WIDTH  (INW),
        .SUM_BIT_WIDTH (SW),
        .RECIP_W       (RW),
        .OUT_BIT_WIDTH (OW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_vec_valid (i_vec_valid),
        .o_vec_ready (o_vec_ready),
        .i_data      (i_data),
        .i_sum_valid (i_sum_valid),
        .i_sum       (i_sum),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_prob      (o_prob),
        .o_idx       (o_idx),
        .o_last      (o_last),
        .o_busy      (o_busy),
        .o_recip_sat (o_recip_sat)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus vector and model expectations
    logic [15:0] cur_x [N];
    logic [31:0] cur_sum;
    logic [15:0] exp_prob [N];
    logic        exp_sat;
    logic [15:0] got_prob [N];

    int          exp_idx = 0;
    int          beats = 0;
    bit          chk_en = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_prob;
    logic [4:0]  prev_idx;
    int          rdy_mode = 0;

    // Plain-arithmetic model: recip = floor(2^42/sum) or all ones when
    // sum <= 1024; prob = min(0xFFFF, (max(x,0) * recip) >> 13).
    function automatic void build_model();
        logic [63:0] recip;
        logic [63:0] xv;
        logic [63:0] p;
        exp_sat = (cur_sum <= 32'd1024);
        recip   = exp_sat ? 64'hFFFF_FFFF : ((64'd1 << 42) / {32'd0, cur_sum});
        for (int i = 0; i < N; i++) begin
            xv = cur_x[i][15] ? 64'd0 : {48'd0, cur_x[i]};
            p  = (xv * recip) >> 13;
            exp_prob[i] = (p > 64'hFFFF) ? 16'hFFFF : p[15:0];
        end
    endfunction

    // Per-cycle output checker
    initial begin
        forever begin
            @(negedge i_clk);
            if (chk_en && o_valid) begin
                check("o_idx order", {59'd0, o_idx}, 64'(exp_idx));
                check("o_prob vs model", {48'd0, o_prob}, {48'd0, exp_prob[o_idx]});
                check("o_last", {63'd0, o_last}, {63'd0, (o_idx == 5'(N - 1))});
                if (prev_stall) begin
                    check("stall o_prob stable", {48'd0, o_prob}, {48'd0, prev_prob});
                    check("stall o_idx stable", {59'd0, o_idx}, {59'd0, prev_idx});
                end
                if (i_ready) begin
                    got_prob[o_idx] = o_prob;
                    exp_idx++;
                    beats++;
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    prev_prob  = o_prob;
                    prev_idx   = o_idx;
                end
            end else begin
                prev_stall = 0;
                if (chk_en) check("o_last while idle", {63'd0, o_last}, 64'd0);
            end
        end
    end

    // Ready driver
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            i_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    task automatic start_vec(input bit same_cycle);
        int t;
        build_model();
        for (int i = 0; i < N; i++) got_prob[i] = 16'hDEAD;
        exp_idx = 0;
        beats   = 0;
        chk_en  = 1;
        t = 0;
        while (!o_vec_ready && t < 200) begin
            @(posedge i_clk); #1; t++;
        end
        check("o_vec_ready before load", {63'd0, o_vec_ready}, 64'd1);
        for (int i = 0; i < N; i++) i_data[i*INW +: INW] = cur_x[i];
        i_vec_valid = 1'b1;
        i_sum_valid = same_cycle;
        i_sum       = cur_sum;
        @(posedge i_clk); #1;
        i_vec_valid = 1'b0;
        i_sum_valid = 1'b0;
        if (!same_cycle) begin
            check("wait_sum o_busy", {63'd0, o_busy}, 64'd1);
            check("wait_sum o_vec_ready", {63'd0, o_vec_ready}, 64'd0);
            // A vector offered while waiting for the sum must be ignored.
            i_data      = ~i_data;
            i_vec_valid = 1'b1;
            @(posedge i_clk); #1;
            i_vec_valid = 1'b0;
            i_sum_valid = 1'b1;
            @(posedge i_clk); #1;
            i_sum_valid = 1'b0;
        end
        check("div o_recip_sat cleared", {63'd0, o_recip_sat}, 64'd0);
        check("div o_valid low", {63'd0, o_valid}, 64'd0);
    endtask

    // Called right after start_vec: counts cycles from the sum-valid cycle.
    task automatic wait_first(output int lat);
        lat = 1;
        while (!o_valid && lat < 100) begin
            @(posedge i_clk); #1; lat++;
        end
        check("first o_valid seen", {63'd0, o_valid}, 64'd1);
        check("o_recip_sat vs model", {63'd0, o_recip_sat}, {63'd0, exp_sat});
    endtask

    task automatic finish_stream();
        int t;
        t = 0;
        while (beats < N && t < 1000) begin
            @(posedge i_clk); #1; t++;
        end
        check("accepted beats", 64'(beats), 64'(N));
        check("o_valid after last", {63'd0, o_valid}, 64'd0);
        check("o_busy after stream", {63'd0, o_busy}, 64'd0);
        check("o_vec_ready after stream", {63'd0, o_vec_ready}, 64'd1);
        chk_en = 0;
    endtask

    task automatic clear_x();
        for (int i = 0; i < N; i++) cur_x[i] = 16'h0000;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, " o_valid"}, {63'd0, o_valid}, 64'd0);
        check({tag, " o_busy"}, {63'd0, o_busy}, 64'd0);
        check({tag, " o_recip_sat"}, {63'd0, o_recip_sat}, 64'd0);
        check({tag, " o_last"}, {63'd0, o_last}, 64'd0);
        check({tag, " o_prob"}, {48'd0, o_prob}, 64'd0);
        check({tag, " o_idx"}, {59'd0, o_idx}, 64'd0);
    endtask

    task automatic pulse_reset(input string tag);
        chk_en  = 0;
        i_rst_n = 1'b0;
        #1;
        check_reset_outs(tag);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        check({tag, " o_vec_ready after release"}, {63'd0, o_vec_ready}, 64'd1);
    endtask

    initial begin
        int lat;
        int t;

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_outs("reset");
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        check("o_vec_ready after reset", {63'd0, o_vec_ready}, 64'd1);

        // Sum alone in IDLE is ignored
        i_sum_valid = 1'b1;
        i_sum       = 32'h0400_0000;
        @(posedge i_clk); #1;
        i_sum_valid = 1'b0;
        check("sum alone ignored", {63'd0, o_busy}, 64'd0);

        // Sum 1.0, x[0] = 1.0
        clear_x();
        cur_x[0] = 16'h1000;
        cur_sum  = 32'h0400_0000;
        rdy_mode = 0;
        start_vec(0);
        wait_first(lat);
        finish_stream();
        check("t1 prob[0]", {48'd0, got_prob[0]}, 64'h8000);
        check("t1 prob[7]", {48'd0, got_prob[7]}, 64'h0000);
        check("t1 recip_sat", {63'd0, o_recip_sat}, 64'd0);

        // All 0.5, sum 16.0
        for (int i = 0; i < N; i++) cur_x[i] = 16'h0800;
        cur_sum = 32'h4000_0000;
        start_vec(0);
        wait_first(lat);
        check("t2 latency", 64'(lat), 64'(RW + 2));
        finish_stream();
        check("t2 prob[0]", {48'd0, got_prob[0]}, 64'h0400);
        check("t2 prob[31]", {48'd0, got_prob[31]}, 64'h0400);

        // Saturation boundary
        clear_x();
        cur_x[0] = 16'h1000;
        cur_sum  = 32'h0000_0000;
        start_vec(0);
        wait_first(lat);
        finish_stream();
        check("sum=0 recip_sat", {63'd0, o_recip_sat}, 64'd1);
        check("sum=0 prob[0]", {48'd0, got_prob[0]}, 64'hFFFF);
        cur_sum = 32'h0000_0400;
        start_vec(1);
        wait_first(lat);
        finish_stream();
        check("sum=0x400 recip_sat", {63'd0, o_recip_sat}, 64'd1);
        cur_sum = 32'h0000_0401;
        start_vec(1);
        wait_first(lat);
        finish_stream();
        check("sum=0x401 recip_sat", {63'd0, o_recip_sat}, 64'd0);

        // Negative element clamp, sum 2.0
        clear_x();
        cur_x[3] = 16'hF000;
        cur_x[4] = 16'h1000;
        cur_sum  = 32'h0800_0000;
        start_vec(0);
        wait_first(lat);
        finish_stream();
        check("t4 prob[3]", {48'd0, got_prob[3]}, 64'h0000);
        check("t4 prob[4]", {48'd0, got_prob[4]}, 64'h4000);

        // Random data, random backpressure, same-cycle vector+sum,
        // vector offered during SCALE
        for (int i = 0; i < N; i++) cur_x[i] = 16'($urandom_range(0, 65535));
        cur_sum  = $urandom_range(32'h0400_0000, 32'h7FFF_FFFF);
        rdy_mode = 1;
        start_vec(1);
        wait_first(lat);
        check("same-cycle latency", 64'(lat), 64'(RW + 2));
        t = 0;
        while (beats < 3 && t < 200) begin
            @(posedge i_clk); #1; t++;
        end
        check("scale o_vec_ready", {63'd0, o_vec_ready}, 64'd0);
        for (int i = 0; i < N; i++) i_data[i*INW +: INW] = 16'h1234;
        i_vec_valid = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_vec_valid = 1'b0;
        finish_stream();

        // Reset mid-DIV
        clear_x();
        cur_x[0] = 16'h1000;
        cur_sum  = 32'h0800_0000;
        start_vec(1);
        repeat (10) @(posedge i_clk);
        #1;
        pulse_reset("mid-DIV reset");

        // Reset mid-SCALE with saturated reciprocal
        clear_x();
        cur_x[0] = 16'h1000;
        cur_x[1] = 16'h2000;
        cur_sum  = 32'h0000_0000;
        rdy_mode = 0;
        start_vec(0);
        wait_first(lat);
        @(posedge i_clk); #1;
        check("pre-reset o_idx", {59'd0, o_idx}, 64'd1);
        pulse_reset("mid-SCALE reset");

        // Next vector after reset is processed correctly
        clear_x();
        cur_x[3] = 16'hF000;
        cur_x[4] = 16'h1000;
        cur_sum  = 32'h0800_0000;
        rdy_mode = 1;
        start_vec(1);
        wait_first(lat);
        finish_stream();
        check("post-reset prob[4]", {48'd0, got_prob[4]}, 64'h4000);
        check("post-reset prob[3]", {48'd0, got_prob[3]}, 64'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
